// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared carry-lookahead group size and group propagate/generate helper
package cla_pkg;

    localparam int CLA_GRP = 4;

    // Returns {P, G} for a 4-bit group: P = all bits propagate, G = group generates a carry.
    function automatic logic [1:0] cla_pg(input logic [3:0] a4, input logic [3:0] b4);
        logic [3:0] p;
        logic [3:0] g;
        p = a4 ^ b4;
        g = a4 & b4;
        return {&p, g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])};
    endfunction

endpackage

// File: rtl/cla_group4.sv
// rtl/cla_group4.sv - combinational 4-bit carry-lookahead group with group P/G outputs
module cla_group4
    import cla_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       grp_p,
    output logic       grp_g
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = a ^ b;
    assign g = a & b;

    // Every internal carry is expanded from c_in directly so no bit waits on another.
    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);

    assign s = p ^ c;
    assign {grp_p, grp_g} = cla_pg(a, b);

endmodule

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined CLA adder, one CHUNK slice per stage; CLA_PIPE_ADDSUB_EN adds a sub input
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_PIPE_ADDSUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int GROUPS = CHUNK / CLA_GRP;

    logic sub_in;
`ifdef CLA_PIPE_ADDSUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    logic adv;

    // Level k holds the operands entering stage k: skewed a/b_eff, finished low sum slices, carry.
    logic             v_q   [STAGES];
    logic             c_q   [STAGES];
    logic             sub_q [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];

    logic [CHUNK-1:0] stage_s [STAGES];
    logic             stage_c [STAGES];
    logic [WIDTH-1:0] s_next  [STAGES];

    logic             ov_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [GROUPS-1:0] gp;
        logic [GROUPS-1:0] gg;
        logic [GROUPS-1:0] gc;
        logic [CHUNK-1:0]  ss;
        logic              gco;

        for (genvar i = 0; i < GROUPS; i++) begin : g_grp
            cla_group4 u_grp (
                .a     (a_q[k][k*CHUNK + i*CLA_GRP +: CLA_GRP]),
                .b     (b_q[k][k*CHUNK + i*CLA_GRP +: CLA_GRP]),
                .c_in  (gc[i]),
                .s     (ss[i*CLA_GRP +: CLA_GRP]),
                .grp_p (gp[i]),
                .grp_g (gg[i])
            );
        end

        // Group carries resolve within the cycle from the carry registered by the previous stage.
        always_comb begin
            logic c;
            gc = '0;
            c  = c_q[k];
            for (int i = 0; i < GROUPS; i++) begin
                gc[i] = c;
                c     = gg[i] | (gp[i] & c);
            end
            gco = c;
        end

        assign stage_s[k] = ss;
        assign stage_c[k] = gco;
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_next[k]                     = s_q[k];
            s_next[k][k*CHUNK +: CHUNK]   = stage_s[k];
        end
    end

    assign adv       = !ov_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = ov_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]   <= 1'b0;
                c_q[k]   <= 1'b0;
                sub_q[k] <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
            end
            ov_q   <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            // Subtraction becomes a + ~b + ~cin; b is inverted once at capture.
            v_q[0]   <= in_valid;
            a_q[0]   <= a;
            b_q[0]   <= b ^ {WIDTH{sub_in}};
            c_q[0]   <= cin ^ sub_in;
            sub_q[0] <= sub_in;
            s_q[0]   <= '0;
            for (int k = 1; k < STAGES; k++) begin
                v_q[k]   <= v_q[k-1];
                a_q[k]   <= a_q[k-1];
                b_q[k]   <= b_q[k-1];
                sub_q[k] <= sub_q[k-1];
                s_q[k]   <= s_next[k-1];
                c_q[k]   <= stage_c[k-1];
            end
            ov_q   <= v_q[STAGES-1];
            sum_q  <= s_next[STAGES-1];
            cout_q <= stage_c[STAGES-1] ^ sub_q[STAGES-1];
            ovf_q  <= (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &&
                      (s_next[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
            zero_q <= ~|s_next[STAGES-1];
        end
    end

endmodule
